eth_frame_rx: RTL and testbench

Parametrised single-clock Ethernet frame receiver buffer for the RMII path. It accepts the byte stream from the RMII `receiver` (one byte per `byte_valid_i` strobe), stores one frame in an internal buffer, and extracts the destination MAC and EtherType. It filters by destination address, rejects erroneous, oversize and runt frames, and presents the held frame as packed words to the host side until the frame is acknowledged.

---
 rtl/eth_frame_rx.sv | 216 +++++++++++++++++++++
 tb/tb_eth_frame_rx.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_rx.sv
// Single-frame Ethernet receive buffer for the RMII path: stores one frame,
// filters on destination MAC and serves it as big-endian words until acknowledged.
module eth_frame_rx #(
  parameter int          DEPTH     = 2048,
  parameter int          OUT_BYTES = 4,
  parameter int          MAX_LEN   = 1518,
  parameter bit          FILTER_EN = 1'b1,
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
) (
  input  logic                   clk_50_mhz,
  input  logic                   rst,
  input  logic [7:0]             byte_i,
  input  logic                   byte_valid_i,
  input  logic                   crs_dv,
  input  logic                   rx_er,
  output logic                   ready,
  output logic [15:0]            data_count,
  output logic [15:0]            protocol_type,
  input  logic                   read_en,
  output logic [8*OUT_BYTES-1:0] data_o,
  output logic                   empty,
  input  logic                   frame_ack,
  output logic [15:0]            drop_cnt
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LB   = $clog2(OUT_BYTES);
  localparam int ROWS = DEPTH / OUT_BYTES;

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2, HOLD = 2'd3} state_e;

  state_e               state_q, state_d;
  logic [15:0]          wr_cnt_q, wr_cnt_d, rd_ptr_q, rd_ptr_d, drop_cnt_q, drop_cnt_d;
  logic [15:0]          data_count_q, data_count_d, protocol_type_q, protocol_type_d;
  logic [15:0]          etype_q, etype_d;
  logic [47:0]          mac_q, mac_d;
  logic                 ready_q, ready_d, empty_q, empty_d, busy_q, busy_d;
  logic [OUT_BYTES-1:0] mask_q, mask_d;
  logic                 wr_en_s, pop_s, drop_inc_s;
  logic [AW-1:0]        wr_addr_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Receive/hold state machine, next-state and datapath control
  always_comb begin
    state_d         = state_q;
    wr_cnt_d        = wr_cnt_q;
    rd_ptr_d        = rd_ptr_q;
    data_count_d    = data_count_q;
    protocol_type_d = protocol_type_q;
    etype_d         = etype_q;
    mac_d           = mac_q;
    ready_d         = ready_q;
    busy_d          = busy_q;
    wr_en_s         = 1'b0;
    pop_s           = 1'b0;
    drop_inc_s      = 1'b0;
    wr_addr_s       = AW'(wr_cnt_q);
    case (state_q)
      IDLE: begin
        if (byte_valid_i) begin
          wr_en_s   = 1'b1;
          wr_addr_s = {AW{1'b0}};
          wr_cnt_d  = 16'd1;
          mac_d     = {mac_q[39:0], byte_i};
          state_d   = RECV;
        end else begin
          state_d = IDLE;
        end
      end
      RECV: begin
        if (rx_er) begin
          drop_inc_s = 1'b1;
          state_d    = DROP;
        end else if (byte_valid_i) begin
          if (wr_cnt_q == 16'(MAX_LEN)) begin
            drop_inc_s = 1'b1;
            state_d    = DROP;
          end else begin
            wr_en_s  = 1'b1;
            wr_cnt_d = wr_cnt_q + 16'd1;
            if (wr_cnt_q < 16'd6) begin
              mac_d = {mac_q[39:0], byte_i};
            end else begin
              mac_d = mac_q;
            end
            if ((wr_cnt_q == 16'd12) || (wr_cnt_q == 16'd13)) begin
              etype_d = {etype_q[7:0], byte_i};
            end else begin
              etype_d = etype_q;
            end
            // mac_d already includes byte 5 here, so the full address is checked
            if (FILTER_EN && (wr_cnt_q == 16'd5) && (mac_d != LOCAL_MAC) &&
                (mac_d != 48'hFFFF_FFFF_FFFF)) begin
              drop_inc_s = 1'b1;
              state_d    = DROP;
            end else begin
              state_d = RECV;
            end
          end
        end else if (!crs_dv) begin
          if (wr_cnt_q >= 16'd14) begin
            state_d         = HOLD;
            data_count_d    = wr_cnt_q;
            protocol_type_d = etype_q;
            ready_d         = 1'b1;
            rd_ptr_d        = 16'd0;
            busy_d          = 1'b0;
          end else begin
            drop_inc_s = 1'b1;
            state_d    = IDLE;
          end
        end else begin
          state_d = RECV;
        end
      end
      DROP: begin
        if (!crs_dv) begin
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      HOLD: begin
        if (byte_valid_i && !busy_q) begin
          drop_inc_s = 1'b1;
          busy_d     = 1'b1;
        end else if (!crs_dv) begin
          busy_d = 1'b0;
        end else begin
          busy_d = busy_q;
        end
        if (frame_ack) begin
          ready_d = 1'b0;
          busy_d  = 1'b0;
          state_d = crs_dv ? DROP : IDLE;
        end else if (read_en && !empty_q) begin
          pop_s    = 1'b1;
          rd_ptr_d = rd_ptr_q + 16'(OUT_BYTES);
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = DROP;
      end
    endcase
    drop_cnt_d = drop_inc_s ? sat_inc(drop_cnt_q) : drop_cnt_q;
    empty_d    = (state_d != HOLD) || (rd_ptr_d >= data_count_d);
  end

  // Lane-valid mask for the popped word; lanes past the frame end read as zero
  always_comb begin
    mask_d = mask_q;
    for (int b = 0; b < OUT_BYTES; b++) begin
      if (pop_s) begin
        mask_d[b] = ({1'b0, rd_ptr_q} + 17'(b)) < {1'b0, data_count_q};
      end else begin
        mask_d[b] = mask_q[b];
      end
    end
  end

  // Control registers; reset parks in DROP so a mid-frame reset cannot capture a partial frame
  always_ff @(posedge clk_50_mhz) begin
    if (rst) begin
      state_q         <= DROP;
      wr_cnt_q        <= 16'd0;
      rd_ptr_q        <= 16'd0;
      drop_cnt_q      <= 16'd0;
      data_count_q    <= 16'd0;
      protocol_type_q <= 16'd0;
      etype_q         <= 16'd0;
      mac_q           <= 48'd0;
      ready_q         <= 1'b0;
      empty_q         <= 1'b1;
      busy_q          <= 1'b0;
      mask_q          <= {OUT_BYTES{1'b0}};
    end else begin
      state_q         <= state_d;
      wr_cnt_q        <= wr_cnt_d;
      rd_ptr_q        <= rd_ptr_d;
      drop_cnt_q      <= drop_cnt_d;
      data_count_q    <= data_count_d;
      protocol_type_q <= protocol_type_d;
      etype_q         <= etype_d;
      mac_q           <= mac_d;
      ready_q         <= ready_d;
      empty_q         <= empty_d;
      busy_q          <= busy_d;
      mask_q          <= mask_d;
    end
  end

  for (genvar b = 0; b < OUT_BYTES; b++) begin : g_bank
    logic [7:0] mem_q [ROWS];
    logic [7:0] rd_q;
    // Byte bank b holds addresses congruent to b modulo OUT_BYTES; registered read
    always_ff @(posedge clk_50_mhz) begin
      if (wr_en_s && (((wr_addr_s ^ AW'(b)) & AW'(OUT_BYTES - 1)) == {AW{1'b0}})) begin
        mem_q[wr_addr_s[AW-1:LB]] <= byte_i;
      end
      if (pop_s) begin
        rd_q <= mem_q[rd_ptr_q[AW-1:LB]];
      end
    end
    assign data_o[8*(OUT_BYTES-1-b) +: 8] = rd_q & {8{mask_q[b]}};
  end

  assign ready         = ready_q;
  assign data_count    = data_count_q;
  assign protocol_type = protocol_type_q;
  assign empty         = empty_q;
  assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_eth_frame_rx.sv
// Self-checking bench for eth_frame_rx: a filtering and a non-filtering instance
// share one stimulus stream and are checked against a queue-based frame model.
module tb_eth_frame_rx;
  localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam int          MAXL  = 1518;

  typedef logic [7:0] bq_t [$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0, crs_dv = 1'b0, rx_er = 1'b0, read_en = 1'b0, frame_ack = 1'b0;
  logic        ready, empty, ready2, empty2;
  logic [15:0] data_count, protocol_type, drop_cnt, data_count2, protocol_type2, drop_cnt2;
  logic [31:0] data_o, data_o2;
  int          checks = 0;
  int          errors = 0;

  always #10 clk = ~clk;

  eth_frame_rx #(.FILTER_EN(1'b1)) dut (
    .clk_50_mhz(clk), .rst(rst), .byte_i(byte_i), .byte_valid_i(byte_valid_i), .crs_dv(crs_dv),
    .rx_er(rx_er), .ready(ready), .data_count(data_count), .protocol_type(protocol_type),
    .read_en(read_en), .data_o(data_o), .empty(empty), .frame_ack(frame_ack), .drop_cnt(drop_cnt));

  eth_frame_rx #(.FILTER_EN(1'b0)) dut2 (
    .clk_50_mhz(clk), .rst(rst), .byte_i(byte_i), .byte_valid_i(byte_valid_i), .crs_dv(crs_dv),
    .rx_er(rx_er), .ready(ready2), .data_count(data_count2), .protocol_type(protocol_type2),
    .read_en(read_en), .data_o(data_o2), .empty(empty2), .frame_ack(frame_ack), .drop_cnt(drop_cnt2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bq_t mk_frame(logic [47:0] dst, logic [15:0] et, int len, bit rnd);
    bq_t f;
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      if (i < 6) b = dst[47-8*i -: 8];
      else if (i == 12) b = et[15:8];
      else if (i == 13) b = et[7:0];
      else if (rnd) b = 8'($urandom);
      else b = 8'(i);
      f.push_back(b);
    end
    return f;
  endfunction

  function automatic logic [31:0] exp_word(bq_t f, int k);
    logic [31:0] w = 32'h0;
    for (int j = 0; j < 4; j++) begin
      if (4 * k + j < f.size()) w[31-8*j -: 8] = f[4*k+j];
    end
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1; crs_dv = 1'b0; byte_valid_i = 1'b0; rx_er = 1'b0; read_en = 1'b0; frame_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send_frame(input bq_t f, input int er_at, input int ack_at, input int rst_at, input bit gaps);
    crs_dv = 1'b1;
    for (int i = 0; i < f.size(); i++) begin
      byte_valid_i = 1'b1; byte_i = f[i];
      rx_er = (i == er_at); frame_ack = (i == ack_at); rst = (i == rst_at);
      tick();
      byte_valid_i = 1'b0; rx_er = 1'b0; frame_ack = 1'b0; rst = 1'b0;
      if (gaps) repeat ($urandom_range(3, 0)) tick();
    end
    crs_dv = 1'b0;
    tick();
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic read_check(input bq_t f, input string nm, input bit c1, input bit c2, output logic [31:0] last);
    int          nw = (f.size() + 3) / 4;
    logic [31:0] w = 32'h0;
    checks++;
    if ((c1 ? empty : empty2) !== 1'b0) begin
      errors++; $display("FAIL %s pre-read empty: got %b want 0", nm, c1 ? empty : empty2);
    end
    read_en = 1'b1;
    for (int k = 0; k < nw; k++) begin
      tick();
      w = exp_word(f, k);
      if (c1) begin
        checks++;
        if (data_o !== w) begin errors++; $display("FAIL %s word %0d: got %h want %h", nm, k, data_o, w); end
      end
      if (c2) begin
        checks++;
        if (data_o2 !== w) begin errors++; $display("FAIL %s nf word %0d: got %h want %h", nm, k, data_o2, w); end
      end
      checks++;
      if ((c1 ? empty : empty2) !== (k == nw - 1)) begin
        errors++; $display("FAIL %s empty after word %0d: got %b want %b", nm, k, c1 ? empty : empty2, k == nw - 1);
      end
    end
    tick();
    read_en = 1'b0;
    last = c1 ? data_o : data_o2;
    checks++;
    if (last !== w) begin errors++; $display("FAIL %s hold when empty: got %h want %h", nm, last, w); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({ready, data_count, protocol_type, data_o, empty, drop_cnt} !== {1'b0, 16'd0, 16'd0, 32'd0, 1'b1, 16'd0}) begin
      errors++; $display("FAIL reset outputs: got r=%b dc=%0d pt=%h d=%h e=%b drop=%0d want 0,0,0,0,1,0",
                         ready, data_count, protocol_type, data_o, empty, drop_cnt);
    end
    do_reset();
    checks++;
    if ({ready, empty, drop_cnt} !== {1'b0, 1'b1, 16'd0}) begin
      errors++; $display("FAIL post-reset idle: got r=%b e=%b drop=%0d want 0,1,0", ready, empty, drop_cnt);
    end
  endtask

  task automatic test_basic();
    bq_t f = mk_frame(LMAC, 16'h0800, 64, 1'b0);
    logic [31:0] last;
    do_reset();
    send_frame(f, -1, -1, -1, 1'b1);
    checks++;
    if ({ready, data_count, protocol_type, drop_cnt} !== {1'b1, 16'd64, 16'h0800, 16'd0}) begin
      errors++; $display("FAIL basic capture: got r=%b dc=%0d pt=%h drop=%0d want 1,64,0800,0",
                         ready, data_count, protocol_type, drop_cnt);
    end
    read_check(f, "basic", 1'b1, 1'b1, last);
    ack();
    checks++;
    if ({ready, empty} !== 2'b01) begin errors++; $display("FAIL basic ack: got r=%b e=%b want 0,1", ready, empty); end
  endtask

  task automatic test_bcast61();
    bq_t f = mk_frame(BCAST, 16'h86DD, 61, 1'b0);
    logic [31:0] last;
    do_reset();
    send_frame(f, -1, -1, -1, 1'b0);
    checks++;
    if ({ready, data_count, protocol_type} !== {1'b1, 16'd61, 16'h86DD}) begin
      errors++; $display("FAIL bcast61 capture: got r=%b dc=%0d pt=%h want 1,61,86dd", ready, data_count, protocol_type);
    end
    read_check(f, "bcast61", 1'b1, 1'b0, last);
    checks++;
    if (last !== 32'h3C000000) begin errors++; $display("FAIL bcast61 last word: got %h want 3c000000", last); end
    ack();
  endtask

  task automatic test_filter();
    bq_t f = mk_frame(48'h02_00_00_00_00_02, 16'h0800, 64, 1'b1);
    logic [31:0] last;
    do_reset();
    send_frame(f, -1, -1, -1, 1'b1);
    checks++;
    if ({ready, drop_cnt} !== {1'b0, 16'd1}) begin
      errors++; $display("FAIL filter reject: got r=%b drop=%0d want 0,1", ready, drop_cnt);
    end
    checks++;
    if ({ready2, data_count2, drop_cnt2} !== {1'b1, 16'd64, 16'd0}) begin
      errors++; $display("FAIL nofilter accept: got r=%b dc=%0d drop=%0d want 1,64,0", ready2, data_count2, drop_cnt2);
    end
    read_check(f, "nofilter", 1'b0, 1'b1, last);
    ack();
  endtask

  task automatic test_drops();
    for (int c = 0; c < 3; c++) begin
      bq_t f = mk_frame(LMAC, 16'h0800, (c == 0) ? 64 : (c == 1) ? MAXL + 1 : 10, 1'b1);
      do_reset();
      send_frame(f, (c == 0) ? 30 : -1, -1, -1, c != 1);
      checks++;
      if ({ready, ready2, drop_cnt, drop_cnt2} !== {1'b0, 1'b0, 16'd1, 16'd1}) begin
        errors++; $display("FAIL drop case %0d: got r=%b r2=%b drop=%0d drop2=%0d want 0,0,1,1",
                           c, ready, ready2, drop_cnt, drop_cnt2);
      end
    end
  endtask

  task automatic test_boundaries();
    bq_t f14 = mk_frame(BCAST, 16'h1234, 14, 1'b1);
    bq_t fmx = mk_frame(LMAC, 16'h0806, MAXL, 1'b1);
    bq_t f13 = mk_frame(LMAC, 16'h0806, 13, 1'b1);
    logic [31:0] last;
    do_reset();
    send_frame(f14, -1, -1, -1, 1'b0);
    checks++;
    if ({ready, data_count, protocol_type} !== {1'b1, 16'd14, 16'h1234}) begin
      errors++; $display("FAIL min frame: got r=%b dc=%0d pt=%h want 1,14,1234", ready, data_count, protocol_type);
    end
    read_check(f14, "min", 1'b1, 1'b1, last);
    ack();
    send_frame(fmx, -1, -1, -1, 1'b0);
    checks++;
    if ({ready, data_count, drop_cnt} !== {1'b1, 16'(MAXL), 16'd0}) begin
      errors++; $display("FAIL max frame: got r=%b dc=%0d drop=%0d want 1,%0d,0", ready, data_count, drop_cnt, MAXL);
    end
    ack();
    send_frame(f13, -1, -1, -1, 1'b0);
    checks++;
    if ({ready, drop_cnt, data_count} !== {1'b0, 16'd1, 16'(MAXL)}) begin
      errors++; $display("FAIL runt13: got r=%b drop=%0d dc=%0d want 0,1,%0d", ready, drop_cnt, data_count, MAXL);
    end
  endtask

  task automatic test_back_to_back();
    bq_t a = mk_frame(LMAC, 16'h0800, 40, 1'b1);
    bq_t b = mk_frame(BCAST, 16'h88CC, 50, 1'b1);
    bq_t c = mk_frame(LMAC, 16'h86DD, 70, 1'b1);
    logic [31:0] last;
    do_reset();
    send_frame(a, -1, -1, -1, 1'b1);
    send_frame(b, -1, -1, -1, 1'b1);
    checks++;
    if ({ready, data_count, protocol_type, drop_cnt} !== {1'b1, 16'd40, 16'h0800, 16'd1}) begin
      errors++; $display("FAIL b2b hold: got r=%b dc=%0d pt=%h drop=%0d want 1,40,0800,1",
                         ready, data_count, protocol_type, drop_cnt);
    end
    read_check(a, "b2b first", 1'b1, 1'b1, last);
    ack();
    send_frame(c, -1, -1, -1, 1'b1);
    checks++;
    if ({ready, data_count, protocol_type, drop_cnt} !== {1'b1, 16'd70, 16'h86DD, 16'd1}) begin
      errors++; $display("FAIL b2b third: got r=%b dc=%0d pt=%h drop=%0d want 1,70,86dd,1",
                         ready, data_count, protocol_type, drop_cnt);
    end
    read_check(c, "b2b third", 1'b1, 1'b1, last);
    send_frame(b, -1, 10, -1, 1'b0);
    checks++;
    if ({ready, data_count, drop_cnt} !== {1'b0, 16'd70, 16'd2}) begin
      errors++; $display("FAIL ack mid-frame: got r=%b dc=%0d drop=%0d want 0,70,2", ready, data_count, drop_cnt);
    end
  endtask

  task automatic test_ack_collision();
    bq_t f = mk_frame(LMAC, 16'h0800, 32, 1'b1);
    bq_t g = mk_frame(BCAST, 16'h0801, 45, 1'b1);
    logic [31:0] last;
    do_reset();
    send_frame(f, -1, -1, -1, 1'b0);
    read_en = 1'b1; frame_ack = 1'b1;
    tick();
    read_en = 1'b0; frame_ack = 1'b0;
    checks++;
    if ({ready, empty, data_o, data_count} !== {1'b0, 1'b1, 32'd0, 16'd32}) begin
      errors++; $display("FAIL ack+read: got r=%b e=%b d=%h dc=%0d want 0,1,0,32", ready, empty, data_o, data_count);
    end
    send_frame(g, -1, -1, -1, 1'b1);
    read_check(g, "after collision", 1'b1, 1'b1, last);
    ack();
  endtask

  task automatic test_reset_midframe();
    bq_t p = mk_frame(LMAC, 16'h0800, 32, 1'b1);
    bq_t f = mk_frame(LMAC, 16'h0800, 64, 1'b1);
    bq_t q = mk_frame(BCAST, 16'h0842, 48, 1'b1);
    logic [31:0] last;
    do_reset();
    send_frame(p, -1, -1, -1, 1'b0);
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    ack();
    send_frame(f, -1, -1, 20, 1'b1);
    checks++;
    if ({ready, data_count, protocol_type, data_o, empty, drop_cnt} !== {1'b0, 16'd0, 16'd0, 32'd0, 1'b1, 16'd0}) begin
      errors++; $display("FAIL mid-frame reset: got r=%b dc=%0d pt=%h d=%h e=%b drop=%0d want 0,0,0,0,1,0",
                         ready, data_count, protocol_type, data_o, empty, drop_cnt);
    end
    send_frame(q, -1, -1, -1, 1'b1);
    checks++;
    if ({ready, data_count, protocol_type, drop_cnt} !== {1'b1, 16'd48, 16'h0842, 16'd0}) begin
      errors++; $display("FAIL post-reset frame: got r=%b dc=%0d pt=%h drop=%0d want 1,48,0842,0",
                         ready, data_count, protocol_type, drop_cnt);
    end
    read_check(q, "post-reset", 1'b1, 1'b1, last);
    ack();
  endtask

  task automatic test_random();
    int exp_d1 = 0;
    int exp_d2 = 0;
    logic [31:0] last;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      logic [47:0] dst;
      int          len, er_at;
      bit          acc1, acc2;
      bq_t         f;
      case ($urandom_range(2, 0))
        0:       dst = LMAC;
        1:       dst = BCAST;
        default: dst = {40'h02_00_00_00_00, 8'($urandom_range(255, 2))};
      endcase
      len   = ($urandom_range(7, 0) == 0) ? $urandom_range(13, 5) : $urandom_range(96, 14);
      er_at = ($urandom_range(5, 0) == 0) ? $urandom_range(len - 1, 1) : -1;
      f     = mk_frame(dst, 16'($urandom), len, 1'b1);
      acc2  = (er_at < 0) && (len >= 14) && (len <= MAXL);
      acc1  = acc2 && ((dst == LMAC) || (dst == BCAST));
      exp_d1 += acc1 ? 0 : 1;
      exp_d2 += acc2 ? 0 : 1;
      send_frame(f, er_at, -1, -1, 1'b1);
      checks++;
      if ({ready, ready2, drop_cnt, drop_cnt2} !== {acc1, acc2, 16'(exp_d1), 16'(exp_d2)}) begin
        errors++; $display("FAIL random %0d status: got r=%b r2=%b drop=%0d drop2=%0d want %b,%b,%0d,%0d",
                           n, ready, ready2, drop_cnt, drop_cnt2, acc1, acc2, exp_d1, exp_d2);
      end
      if (acc2) begin
        checks++;
        if ({data_count2, protocol_type2} !== {16'(len), f[12], f[13]}) begin
          errors++; $display("FAIL random %0d header: got dc=%0d pt=%h want %0d,%h%h",
                             n, data_count2, protocol_type2, len, f[12], f[13]);
        end
        read_check(f, "random", acc1, 1'b1, last);
        ack();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bcast61();
    test_filter();
    test_drops();
    test_boundaries();
    test_back_to_back();
    test_ack_collision();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
